ulbf_slave_seq: RTL and testbench
=================================

Name: ulbf_slave_seq

Overview:
- Capture-and-readback sequencer for the uplink beamformer slave receive RAM.
- Resets the slave capture logic, programs the iteration count and waits for receive-done.
- Then streams the captured 64-bit words out of the RAM port-B read interface as a flow-controlled stream.
- Sits beside the slave RAM/CDC logic in the AXI-Lite clock domain; its config inputs are driven from software-visible registers.

Parameters:
- RD_LATENCY, 4: cycles from enb/addrb issue to valid doutb.
- FIFO_DEPTH, 8: readback skid FIFO entries; must be >= RD_LATENCY+2.
- RAM_DEPTH, 1536: maximum number of readable words; the read count is clamped to this.
- RST_CYCLES, 16: cycles slave_rst is held high per run.
- TIMEOUT_WIDTH, 24: width of cfg_timeout.

Ports:
- s_axi_aclk  in  1  sole clock.
- s_axi_aresetn  in  1  asynchronous active-low reset.
- start  in  1  single-cycle run request.
- abort  in  1  single-cycle run cancel.
- cfg_niter  in  12  iteration count for the slave.
- cfg_words  in  16  words to read back; 0 means use rxram_counter.
- cfg_timeout  in  TIMEOUT_WIDTH  receive-wait cycle limit; 0 disables the limit.
- slave_rst  out  1  slave capture reset.
- niter  out  12  latched iteration count.
- rxdone  in  1  slave receive complete (level).
- rxram_counter  in  16  words captured by the slave.
- enb  out  1  RAM port-B read enable.
- addrb  out  16  RAM port-B word address.
- doutb  in  64  RAM port-B read data.
- rd_tvalid  out  1  readback stream valid.
- rd_tdata  out  64  readback stream data.
- rd_tlast  out  1  marks the final word.
- rd_tready  in  1  readback stream ready.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on successful completion.
- err_timeout  out  1  sticky; cleared by the next accepted start.
- words_read  out  16  words accepted on the stream in this run.
- state  out  3  current FSM state encoding.

Behaviour:
- Reset: all outputs are 0. FSM is in IDLE, FIFO empty, all counters 0.
- States: IDLE=0, SRST=1, ARM=2, WAIT_RX=3, READ=4, DRAIN=5.
- IDLE:
  - start accepted: latch cfg_niter into niter, clear err_timeout and words_read, enter SRST.
  - start while busy is ignored.
- SRST:
  - slave_rst=1 for exactly RST_CYCLES cycles, then enter ARM.
- ARM:
  - slave_rst=0 for one cycle; timeout counter cleared; enter WAIT_RX.
- WAIT_RX:
  - Timeout counter increments every cycle.
  - rxdone=1: sample N = (cfg_words==0 ? rxram_counter : cfg_words), clamped to RAM_DEPTH.
    - N=0: pulse done, return to IDLE; no stream beats.
    - Otherwise enter READ.
  - cfg_timeout!=0 and the counter reaches cfg_timeout before rxdone: set err_timeout, return to IDLE, no done pulse.
- READ:
  - Issue rule: drive enb=1 with addrb=issue_cnt when (inflight + fifo_count) < FIFO_DEPTH and issue_cnt < N.
  - Addresses go 0..N-1 in order, one per cycle maximum.
  - Each issue launches a token down an RD_LATENCY-deep valid pipe; doutb is written to the FIFO in the cycle the token exits.
  - After the last issue, enter DRAIN.
  - enb=0 whenever no issue occurs; addrb holds its last value.
- DRAIN:
  - Wait for the FIFO to empty and for the last word to be accepted.
  - Then pulse done, return to IDLE.
- Stream rules:
  - rd_tvalid = FIFO not empty; rd_tdata = FIFO head.
  - rd_tvalid, rd_tdata and rd_tlast stay stable until rd_tready.
  - rd_tlast=1 on the beat with words_read==N-1.
  - words_read increments on each rd_tvalid&&rd_tready.
  - Back-to-back throughput is 1 word/cycle when rd_tready is held high.
- Abort (any non-IDLE state):
  - Next cycle: FSM is IDLE, FIFO and valid pipe are flushed, enb=0, slave_rst=0, rd_tvalid=0.
  - No done pulse; err_timeout unchanged.
  - Abort and start in the same cycle: abort wins and the start is dropped.
- Overflow safety: the FIFO never overflows, because the inflight count includes tokens still in the pipe.
- rxdone is sampled only in WAIT_RX; a stale rxdone high at ARM exit is accepted immediately.

Optional Feature:
- Macro: ULBF_SLAVE_SEQ_CHECKSUM_EN.
- Defined:
  - Adds output checksum [31:0], reset 0, cleared on accepted start.
  - On each accepted beat, adds rd_tdata[63:32]+rd_tdata[31:0] modulo 2^32.
  - Value is final in the cycle done pulses.
- Not defined: the port is absent and no adder logic is built.

Test Plan:
1. cfg_niter=5, cfg_words=0, rxram_counter=10, rxdone 40 cycles after ARM, RAM word k=k, rd_tready=1 -> slave_rst high exactly 16 cycles; niter=5; 10 beats with data 0..9; rd_tlast on data 9; done pulse; words_read=10.
2. Same as 1 with rd_tready toggling 1-of-3 cycles -> data 0..9 in order, no loss or duplication, rd_tdata stable while stalled, enb never issued with fifo_count+inflight>=8.
3. cfg_timeout=100, rxdone never asserted -> err_timeout=1 at cycle 100 of WAIT_RX; state=IDLE; no done; no enb.
4. cfg_words=2000 -> exactly 1536 beats; last address issued = 1535; rd_tlast on the 1536th beat.
5. Abort on the 3rd beat of a 10-word run, start in the same cycle -> next cycle IDLE, rd_tvalid=0; a start 2 cycles later then runs cleanly with 10 beats from address 0.
6. cfg_words=0 with rxram_counter=0 -> done pulse right after rxdone, zero beats; with ULBF_SLAVE_SEQ_CHECKSUM_EN and case 1 data (word k=k) -> checksum=45.

Source files
------------

// File: rtl/ulbf_slave_seq_if.sv
// RAM port-B read bus and readback stream between the capture sequencer and its RAM/sink.
interface ulbf_slave_seq_if;
    logic        enb;
    logic [15:0] addrb;
    logic [63:0] doutb;
    logic        rd_tvalid;
    logic [63:0] rd_tdata;
    logic        rd_tlast;
    logic        rd_tready;

    modport master (
        output enb, addrb, rd_tvalid, rd_tdata, rd_tlast,
        input  doutb, rd_tready
    );

    modport slave (
        input  enb, addrb, rd_tvalid, rd_tdata, rd_tlast,
        output doutb, rd_tready
    );
endinterface

// File: rtl/ulbf_slave_seq.sv
// Capture-and-readback sequencer for the uplink beamformer slave receive RAM.
// Optional running checksum output enabled by defining ULBF_SLAVE_SEQ_CHECKSUM_EN.
module ulbf_slave_seq #(
    parameter int RD_LATENCY    = 4,
    parameter int FIFO_DEPTH    = 8,
    parameter int RAM_DEPTH     = 1536,
    parameter int RST_CYCLES    = 16,
    parameter int TIMEOUT_WIDTH = 24
) (
    input  logic                     s_axi_aclk,
    input  logic                     s_axi_aresetn,
    input  logic                     start,
    input  logic                     abort,
    input  logic [11:0]              cfg_niter,
    input  logic [15:0]              cfg_words,
    input  logic [TIMEOUT_WIDTH-1:0] cfg_timeout,
    output logic                     slave_rst,
    output logic [11:0]              niter,
    input  logic                     rxdone,
    input  logic [15:0]              rxram_counter,
    ulbf_slave_seq_if.master         bus,
    output logic                     busy,
    output logic                     done,
    output logic                     err_timeout,
    output logic [15:0]              words_read,
    output logic [2:0]               state
`ifdef ULBF_SLAVE_SEQ_CHECKSUM_EN
    ,
    output logic [31:0]              checksum
`endif
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SRST    = 3'd1;
    localparam logic [2:0] S_ARM     = 3'd2;
    localparam logic [2:0] S_WAIT_RX = 3'd3;
    localparam logic [2:0] S_READ    = 3'd4;
    localparam logic [2:0] S_DRAIN   = 3'd5;

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;
    localparam int RST_W = $clog2(RST_CYCLES + 1);

    localparam logic [15:0]      RAM_MAX  = 16'(RAM_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [OCC_W-1:0] OCC_MAX  = OCC_W'(FIFO_DEPTH);
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);

    logic [RST_W-1:0]         rst_cnt;
    logic [TIMEOUT_WIDTH-1:0] tmo_cnt;
    logic [TIMEOUT_WIDTH-1:0] tmo_nxt;
    logic [15:0]              n_words;
    logic [15:0]              issue_cnt;
    logic [15:0]              n_raw;
    logic [15:0]              n_clamped;
    logic [RD_LATENCY-1:0]    vld_p;
    logic [CNT_W-1:0]         inflight;
    logic [CNT_W-1:0]         fifo_cnt;
    logic [OCC_W-1:0]         occupancy;
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [63:0]              fifo_mem [FIFO_DEPTH];
    logic                     start_ok;
    logic                     abort_now;
    logic                     issue;
    logic                     tok_exit;
    logic                     pop;

    assign start_ok  = (state == S_IDLE) && start && !abort;
    assign abort_now = abort && (state != S_IDLE);
    assign tmo_nxt   = tmo_cnt + 1'b1;
    assign n_raw     = (cfg_words == 16'd0) ? rxram_counter : cfg_words;
    assign n_clamped = (n_raw > RAM_MAX) ? RAM_MAX : n_raw;

    // Tokens still in the read pipe count against FIFO space so a burst of returns can never overflow it.
    assign occupancy = OCC_W'(inflight) + OCC_W'(fifo_cnt);
    assign issue     = (state == S_READ) && (occupancy < OCC_MAX) && (issue_cnt < n_words);
    assign tok_exit  = vld_p[RD_LATENCY-1];
    assign pop       = bus.rd_tvalid && bus.rd_tready;

    assign busy          = (state != S_IDLE);
    assign slave_rst     = (state == S_SRST);
    assign bus.rd_tvalid = (fifo_cnt != '0);
    assign bus.rd_tdata  = bus.rd_tvalid ? fifo_mem[rd_ptr] : 64'd0;
    assign bus.rd_tlast  = bus.rd_tvalid && (words_read == n_words - 16'd1);

    // Control FSM and RAM issue port
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state       <= S_IDLE;
            rst_cnt     <= '0;
            tmo_cnt     <= '0;
            n_words     <= '0;
            issue_cnt   <= '0;
            niter       <= '0;
            err_timeout <= 1'b0;
            done        <= 1'b0;
            bus.enb     <= 1'b0;
            bus.addrb   <= '0;
        end else begin
            done    <= 1'b0;
            bus.enb <= issue && !abort_now;
            if (issue && !abort_now) begin
                bus.addrb <= issue_cnt;
                issue_cnt <= issue_cnt + 16'd1;
            end
            if (abort_now) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start_ok) begin
                            niter       <= cfg_niter;
                            err_timeout <= 1'b0;
                            rst_cnt     <= '0;
                            issue_cnt   <= '0;
                            state       <= S_SRST;
                        end
                    end
                    S_SRST: begin
                        if (rst_cnt == RST_LAST) state <= S_ARM;
                        else                     rst_cnt <= rst_cnt + 1'b1;
                    end
                    S_ARM: begin
                        tmo_cnt <= '0;
                        state   <= S_WAIT_RX;
                    end
                    S_WAIT_RX: begin
                        tmo_cnt <= tmo_nxt;
                        if (rxdone) begin
                            n_words <= n_clamped;
                            if (n_clamped == 16'd0) begin
                                done  <= 1'b1;
                                state <= S_IDLE;
                            end else begin
                                state <= S_READ;
                            end
                        end else if ((cfg_timeout != '0) && (tmo_nxt >= cfg_timeout)) begin
                            err_timeout <= 1'b1;
                            state       <= S_IDLE;
                        end
                    end
                    S_READ: begin
                        if (issue && (issue_cnt == n_words - 16'd1)) state <= S_DRAIN;
                    end
                    S_DRAIN: begin
                        if ((inflight == '0) && (fifo_cnt == '0)) begin
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Read-latency token pipe, FIFO bookkeeping and beat counter
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            vld_p      <= '0;
            inflight   <= '0;
            fifo_cnt   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            words_read <= '0;
        end else if (abort_now) begin
            vld_p    <= '0;
            inflight <= '0;
            fifo_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            vld_p[0] <= bus.enb;
            for (int i = 1; i < RD_LATENCY; i++) vld_p[i] <= vld_p[i-1];
            inflight <= inflight + CNT_W'(issue) - CNT_W'(tok_exit);
            fifo_cnt <= fifo_cnt + CNT_W'(tok_exit) - CNT_W'(pop);
            if (tok_exit) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            if (pop)      rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            if (start_ok)  words_read <= '0;
            else if (pop)  words_read <= words_read + 16'd1;
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (tok_exit) fifo_mem[wr_ptr] <= bus.doutb;
    end

`ifdef ULBF_SLAVE_SEQ_CHECKSUM_EN
    logic [31:0] beat_sum;
    assign beat_sum = bus.rd_tdata[63:32] + bus.rd_tdata[31:0];

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn)          checksum <= '0;
        else if (start_ok)           checksum <= '0;
        else if (pop && !abort_now)  checksum <= checksum + beat_sum;
    end
`endif

endmodule

// File: tb/tb_ulbf_slave_seq.sv
// Directed table-driven bench for ulbf_slave_seq with a fixed-latency RAM model (word k = k).
module tb_ulbf_slave_seq;

    localparam int LAT = 4;

    typedef struct {
        logic [11:0] niter;
        logic [15:0] words;
        logic [15:0] rxram;
        bit          slow;
        int          exp_beats;
        logic [31:0] exp_sum;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [11:0] cfg_niter;
    logic [15:0] cfg_words;
    logic [23:0] cfg_timeout;
    logic        slave_rst;
    logic [11:0] niter;
    logic        rxdone;
    logic [15:0] rxram_counter;
    logic        busy;
    logic        done;
    logic        err_timeout;
    logic [15:0] words_read;
    logic [2:0]  state;
`ifdef ULBF_SLAVE_SEQ_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    ulbf_slave_seq_if bus();

    ulbf_slave_seq dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .start         (start),
        .abort         (abort),
        .cfg_niter     (cfg_niter),
        .cfg_words     (cfg_words),
        .cfg_timeout   (cfg_timeout),
        .slave_rst     (slave_rst),
        .niter         (niter),
        .rxdone        (rxdone),
        .rxram_counter (rxram_counter),
        .bus           (bus),
        .busy          (busy),
        .done          (done),
        .err_timeout   (err_timeout),
        .words_read    (words_read),
        .state         (state)
`ifdef ULBF_SLAVE_SEQ_CHECKSUM_EN
        ,
        .checksum      (checksum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM port B: address registered on enb, data appears LAT cycles after the issue cycle
    logic [15:0] ra [LAT];
    always @(posedge clk) begin
        ra[0] <= bus.enb ? bus.addrb : 16'hDEAD;
        for (int i = 1; i < LAT; i++) ra[i] <= ra[i-1];
    end
    assign bus.doutb = {48'd0, ra[LAT-1]};

    int total = 0;
    int bad   = 0;
    vec_t vecs [5];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, exp);
        end
    endtask

    task automatic run_case(input vec_t v);
        int cyc, wait_cnt, srst_cnt, beats, issued, out_now, max_out;
        int rx_cyc, done_cyc, first_beat, last_beat;
        logic [15:0] first_addr, last_addr;
        logic got_done, stalled, held_last;
        logic [63:0] held_data;
        cyc = 0; wait_cnt = 0; srst_cnt = 0; beats = 0; issued = 0; max_out = 0;
        rx_cyc = 0; done_cyc = 0; first_beat = 0; last_beat = 0;
        first_addr = 16'hFFFF; last_addr = 16'hFFFF;
        got_done = 1'b0; stalled = 1'b0; held_last = 1'b0; held_data = '0;
        cfg_niter = v.niter; cfg_words = v.words; rxram_counter = v.rxram;
        cfg_timeout = '0; rxdone = 1'b0; bus.rd_tready = 1'b1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check("start_busy", busy, 1);
        check("start_err_clr", err_timeout, 0);
        check("start_words_clr", words_read, 0);
        while (!got_done && cyc < 6000) begin
            @(negedge clk);
            if (slave_rst) srst_cnt++;
            if (state == 3'd3) wait_cnt++;
            if (bus.enb) begin
                if (issued == 0) first_addr = bus.addrb;
                last_addr = bus.addrb;
                issued++;
            end
            out_now = issued - beats;
            if (out_now > max_out) max_out = out_now;
            if (stalled) begin
                check("stall_valid", bus.rd_tvalid, 1);
                check("stall_data", bus.rd_tdata, held_data);
                check("stall_last", bus.rd_tlast, held_last);
            end
            if (bus.rd_tvalid && bus.rd_tready) begin
                check("beat_data", bus.rd_tdata, 64'(beats));
                check("beat_tlast", bus.rd_tlast, (beats == v.exp_beats - 1));
                if (beats == 0) first_beat = cyc;
                last_beat = cyc;
                beats++;
            end
            stalled   = bus.rd_tvalid && !bus.rd_tready;
            held_data = bus.rd_tdata;
            held_last = bus.rd_tlast;
            if (done) begin
                got_done = 1'b1;
                done_cyc = cyc;
                check("done_state_idle", state, 0);
                check("done_words_read", words_read, v.exp_beats);
`ifdef ULBF_SLAVE_SEQ_CHECKSUM_EN
                check("checksum", checksum, v.exp_sum);
`endif
            end
            @(posedge clk); #1;
            cyc++;
            if (wait_cnt >= 40 && !rxdone) begin
                rxdone = 1'b1;
                rx_cyc = cyc;
            end
            bus.rd_tready = v.slow ? ((cyc % 3) == 0) : 1'b1;
        end
        rxdone = 1'b0;
        bus.rd_tready = 1'b1;
        check("run_done", got_done, 1);
        check("srst_cycles", srst_cnt, 16);
        check("niter", niter, v.niter);
        check("beats", beats, v.exp_beats);
        check("issued", issued, v.exp_beats);
        check("outstanding_le_depth", (max_out <= 8), 1);
        check("err_clear", err_timeout, 0);
        if (v.exp_beats > 0) begin
            check("first_addr", first_addr, 0);
            check("last_addr", last_addr, v.exp_beats - 1);
            if (!v.slow) check("throughput", last_beat - first_beat, v.exp_beats - 1);
        end else begin
            check("zero_done_gap", done_cyc - rx_cyc, 1);
        end
    endtask

    initial begin
        int  wait_cnt, en_cnt, dn_cnt, beats;
        logic left, found;
        vecs[0] = '{12'd5,     16'd0,    16'd10, 1'b0, 10,   32'd45};
        vecs[1] = '{12'd5,     16'd0,    16'd10, 1'b1, 10,   32'd45};
        vecs[2] = '{12'h7FF,   16'd2000, 16'd7,  1'b0, 1536, 32'd1178880};
        vecs[3] = '{12'd1,     16'd0,    16'd0,  1'b0, 0,    32'd0};
        vecs[4] = '{12'hABC,   16'd3,    16'd10, 1'b1, 3,    32'd3};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        cfg_niter = '0; cfg_words = '0; cfg_timeout = '0;
        rxdone = 1'b0; rxram_counter = '0; bus.rd_tready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_state", state, 0);
        check("rst_busy", busy, 0);
        check("rst_slave_rst", slave_rst, 0);
        check("rst_niter", niter, 0);
        check("rst_enb_addr", {bus.enb, bus.addrb}, 0);
        check("rst_stream", {bus.rd_tvalid, bus.rd_tlast, bus.rd_tdata}, 0);
        check("rst_done_err", {done, err_timeout}, 0);
        check("rst_words_read", words_read, 0);
`ifdef ULBF_SLAVE_SEQ_CHECKSUM_EN
        check("rst_checksum", checksum, 0);
`endif
        @(posedge clk); #1 rst_n = 1'b1;

        for (int i = 0; i < 5; i++) run_case(vecs[i]);

        // Receive timeout with rxdone never arriving
        cfg_timeout = 24'd100; cfg_words = 16'd4; rxram_counter = '0; rxdone = 1'b0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_cnt = 0; en_cnt = 0; dn_cnt = 0; left = 1'b0;
        for (int c = 0; c < 1000 && !left; c++) begin
            @(negedge clk);
            if (state == 3'd3) wait_cnt++;
            if (bus.enb) en_cnt++;
            if (done) dn_cnt++;
            if (state == 3'd0) left = 1'b1;
        end
        check("tmo_left", left, 1);
        check("tmo_wait_cycles", wait_cnt, 100);
        check("tmo_err", err_timeout, 1);
        check("tmo_busy", busy, 0);
        check("tmo_no_done", dn_cnt, 0);
        check("tmo_no_enb", en_cnt, 0);
        cfg_timeout = '0;

        // Abort on the third beat with a simultaneous start; stale rxdone held from the start
        cfg_words = 16'd10; rxram_counter = 16'd10; rxdone = 1'b1; bus.rd_tready = 1'b1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check("start_clears_err", err_timeout, 0);
        beats = 0; found = 1'b0;
        for (int c = 0; c < 500 && !found; c++) begin
            @(negedge clk);
            if (bus.rd_tvalid && bus.rd_tready) begin
                if (beats == 2) found = 1'b1;
                else begin
                    check("abort_pre_data", bus.rd_tdata, 64'(beats));
                    beats++;
                end
            end
        end
        check("abort_reach_beat3", found, 1);
        abort = 1'b1; start = 1'b1;
        @(posedge clk); #1 abort = 1'b0; start = 1'b0; rxdone = 1'b0;
        @(negedge clk);
        check("abort_state", state, 0);
        check("abort_tvalid", bus.rd_tvalid, 0);
        check("abort_enb", bus.enb, 0);
        check("abort_slave_rst", slave_rst, 0);
        check("abort_no_done", done, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("abort_start_dropped", state, 0);
        check("abort_still_no_done", done, 0);
        run_case(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
